gsim_matvec: RTL and testbench

- Companion to the Gauss-Seidel solver: takes the solver's 16-word x result stream and recomputes b = A·x for the fixed banded matrix A.
- A has diagonal 20, ±1 band −13, ±2 band 6, ±3 band −1. Entries whose column falls outside 0..N−1 are zero.
- Emits a 16-word b stream in the solver's input format, so results can be looped back or checked on-chip (residual / self-test path).
- Single buffer. Collect phase, then emit phase. No output backpressure.

---
 rtl/gsim_pkg.sv | 23 ++
 rtl/gsim_band_mac.sv | 44 ++++
 rtl/gsim_matvec.sv | 112 +++++++++++
 tb/tb_gsim_matvec.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared constants for the Gauss-Seidel companion blocks: band coefficients,
// vector length, fixed-point formats and the mat-vec FSM states.
package gsim_pkg;

    localparam int N     = 16;
    localparam int FRAC  = 16;
    localparam int ACC_W = 40;

    localparam int X_W   = 32;
    localparam int B_W   = 16;
    localparam int TAPS  = 7;

    localparam int A_DIAG = 20;
    localparam int A_B1   = -13;
    localparam int A_B2   = 6;
    localparam int A_B3   = -1;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/gsim_band_mac.sv
// One row of the banded A times a 7-tap window of x, rounded half toward
// +inf and saturated to the 16-bit b format. Purely combinational.
module gsim_band_mac
    import gsim_pkg::*;
#(
    parameter int FRAC  = gsim_pkg::FRAC,
    parameter int ACC_W = gsim_pkg::ACC_W
) (
    input  logic signed [X_W-1:0] taps [TAPS],
    input  logic        [TAPS-1:0] tap_ok,
    output logic signed [B_W-1:0] b
);

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W-1:0] B_MAX = ACC_W'((2 ** (B_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] B_MIN = ACC_W'(-(2 ** (B_W - 1)));

    logic signed [ACC_W-1:0] t [TAPS];
    logic signed [ACC_W-1:0] s1, s2, s3, acc, rnd;

    // Taps are x[i-3]..x[i+3]; symmetric pairs are summed before the
    // shift-add constant multiplies (20 = 16+4, 13 = 8+4+1, 6 = 4+2).
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            t[k] = tap_ok[k] ? ACC_W'(taps[k]) : '0;
        end
        s1  = t[2] + t[4];
        s2  = t[1] + t[5];
        s3  = t[0] + t[6];
        acc = (t[3] <<< 4) + (t[3] <<< 2)
            - ((s1 <<< 3) + (s1 <<< 2) + s1)
            + ((s2 <<< 2) + (s2 <<< 1))
            - s3;
        rnd = (acc + HALF) >>> FRAC;
        if (rnd > B_MAX) begin
            b = B_MAX[B_W-1:0];
        end else if (rnd < B_MIN) begin
            b = B_MIN[B_W-1:0];
        end else begin
            b = rnd[B_W-1:0];
        end
    end

endmodule

// File: rtl/gsim_matvec.sv
// Collects one N-word x vector, then streams b = A*x one element per cycle.
// Single buffer: input is refused (and flagged) while emitting.
module gsim_matvec
    import gsim_pkg::*;
#(
    parameter int N     = gsim_pkg::N,
    parameter int FRAC  = gsim_pkg::FRAC,
    parameter int ACC_W = gsim_pkg::ACC_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           x_valid,
    input  logic [X_W-1:0] x_in,
    output logic           in_ready,
    output logic           b_valid,
    output logic [B_W-1:0] b_out,
    output logic           drop_err
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t state, state_nxt;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic signed [X_W-1:0] x_buf [N];
    logic signed [X_W-1:0] taps [TAPS];
    logic [TAPS-1:0] tap_ok;
    logic signed [B_W-1:0] b_calc;
    logic accept;

    assign accept = x_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_COLLECT: begin
                in_ready = 1'b1;
                if (x_valid && (wr_idx == LAST)) begin
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (rd_idx == LAST) begin
                    state_nxt = S_COLLECT;
                end
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_buf[wr_idx] <= x_in;
        end
    end

    // Window around rd_idx; taps outside 0..N-1 are masked to zero.
    always_comb begin
        int j;
        j = 0;
        for (int k = 0; k < TAPS; k++) begin
            j         = int'(rd_idx) + k - 3;
            tap_ok[k] = (j >= 0) && (j < N);
            taps[k]   = tap_ok[k] ? x_buf[j[IDX_W-1:0]] : '0;
        end
    end

    gsim_band_mac #(
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_mac (
        .taps   (taps),
        .tap_ok (tap_ok),
        .b      (b_calc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            b_valid  <= 1'b0;
            b_out    <= '0;
            drop_err <= 1'b0;
        end else begin
            drop_err <= x_valid && !in_ready;
            b_valid  <= (state == S_EMIT);
            if (state == S_EMIT) begin
                b_out  <= b_calc;
                rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
            end
            if (accept) begin
                if (wr_idx == LAST) begin
                    wr_idx <= '0;
                    rd_idx <= '0;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gsim_matvec.sv
// Scoreboard bench for gsim_matvec: stimulus pushes expected b words, a
// negedge monitor pops and compares them and tracks handshake timing.
module tb_gsim_matvec;
    import gsim_pkg::*;

    localparam int NV = 16;

    typedef logic [31:0] vec_t [NV];
    typedef int exp_t [NV];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        x_valid = 1'b0;
    logic [31:0] x_in = '0;
    logic        in_ready, b_valid, drop_err;
    logic [15:0] b_out;

    gsim_matvec dut (
        .clk      (clk),
        .reset    (reset),
        .x_valid  (x_valid),
        .x_in     (x_in),
        .in_ready (in_ready),
        .b_valid  (b_valid),
        .b_out    (b_out),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int b_seen = 0;
    int drop_seen = 0;
    int acc_cnt = 0;
    int last_t = 0;
    int b_idx = 0;
    bit have_last = 1'b0;
    bit exp_drop = 1'b0;
    bit exp_ready;
    logic signed [15:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: row i of A has coefficient 20,-13,6,-1 at distance 0..3.
    function automatic longint coef(input int d);
        int ad;
        ad = (d < 0) ? -d : d;
        case (ad)
            0: return 20;
            1: return -13;
            2: return 6;
            3: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic void push_model(input vec_t v);
        longint acc, r;
        for (int i = 0; i < NV; i++) begin
            acc = 0;
            for (int j = 0; j < NV; j++) begin
                acc += coef(i - j) * longint'($signed(v[j]));
            end
            r = (acc + 32768) >>> 16;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            sb.push_back(16'(r));
        end
    endfunction

    function automatic void push_list(input exp_t e);
        for (int i = 0; i < NV; i++) sb.push_back(16'(e[i]));
    endfunction

    task automatic applyStimulus(input vec_t v, input int gap_pct);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < NV) begin
            @(posedge clk);
            #1;
            x_valid = ($urandom_range(99) >= gap_pct);
            x_in    = x_valid ? v[k] : $urandom;
            @(negedge clk);
            if (x_valid && in_ready) k++;
            guard++;
            if (guard > 4000) begin
                checks++;
                errors++;
                $display("[TB] FAIL stimulus timeout: accepted %0d of %0d words", k, NV);
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            x_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        logic signed [15:0] e;
        if (reset) begin
            checkOutput("reset b_valid", b_valid, 0);
            checkOutput("reset in_ready", in_ready, 1);
            checkOutput("reset b_out", b_out, 0);
            checkOutput("reset drop_err", drop_err, 0);
            sb.delete();
            acc_cnt   = 0;
            have_last = 1'b0;
            exp_drop  = 1'b0;
            b_idx     = 0;
        end else begin
            exp_ready = !(have_last && cyc > last_t && cyc <= last_t + NV);
            checkOutput("in_ready", in_ready, exp_ready);
            checkOutput("drop_err", drop_err, exp_drop);
            if (drop_err) drop_seen++;
            if (b_valid) begin
                b_seen++;
                if (b_idx == 0) checkOutput("b latency", cyc - last_t, 2);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected b_valid: b_out=%0d, scoreboard empty", $signed(b_out));
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("b[%0d]", b_idx), longint'($signed(b_out)), longint'(e));
                end
                b_idx = (b_idx + 1) % NV;
            end
            exp_drop = x_valid && !exp_ready;
            if (x_valid && exp_ready) begin
                acc_cnt++;
                if (acc_cnt == NV) begin
                    acc_cnt   = 0;
                    last_t    = cyc;
                    have_last = 1'b1;
                end
            end
        end
    end

    initial begin
        vec_t v, w;
        exp_t e_ones, e_unit, e_round;
        int base, g, d0;

        e_ones  = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
        e_unit  = '{0, 0, -1, 6, -13, 20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0};
        e_round = '{10, -6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        $display("[TB] all-ones vector");
        foreach (v[i]) v[i] = 32'h0001_0000;
        push_list(e_ones);
        applyStimulus(v, 0);
        idle(NV + 4);

        $display("[TB] unit vector at index 5");
        foreach (v[i]) v[i] = '0;
        v[5] = 32'h0001_0000;
        push_list(e_unit);
        applyStimulus(v, 0);
        idle(NV + 4);

        $display("[TB] rounding vector");
        foreach (v[i]) v[i] = '0;
        v[0] = 32'h0000_8000;
        push_list(e_round);
        applyStimulus(v, 0);
        idle(NV + 4);

        $display("[TB] saturation vector");
        foreach (v[i]) v[i] = 32'h7FFF_FFFF;
        push_model(v);
        applyStimulus(v, 0);
        idle(NV + 4);

        $display("[TB] random vectors with gaps");
        for (int n = 0; n < 6; n++) begin
            foreach (v[i]) v[i] = (n < 4) ? ($urandom_range(32'h00FF_FFFF) - 32'h0080_0000) : $urandom;
            push_model(v);
            applyStimulus(v, 40);
            idle(NV + 3);
        end

        $display("[TB] x_valid held through emit");
        foreach (v[i]) v[i] = $urandom_range(32'h00FF_FFFF) - 32'h0080_0000;
        foreach (w[i]) w[i] = $urandom_range(32'h00FF_FFFF) - 32'h0080_0000;
        d0 = drop_seen;
        push_model(v);
        applyStimulus(v, 0);
        push_model(w);
        applyStimulus(w, 0);
        idle(NV + 4);
        checkOutput("drop count", drop_seen - d0, NV);

        $display("[TB] reset during emit");
        foreach (v[i]) v[i] = 32'h0001_0000;
        base = b_seen;
        push_list(e_ones);
        applyStimulus(v, 0);
        idle(1);
        g = 0;
        while (b_seen < base + 8 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait for 8th b_valid: saw %0d, expected %0d", b_seen - base, 8);
        end
        reset = 1'b1;
        #1;
        checkOutput("b_valid at reset", b_valid, 0);
        checkOutput("in_ready at reset", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(2);
        push_list(e_ones);
        applyStimulus(v, 0);
        idle(NV + 4);

        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        checkOutput("scoreboard drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
